ma_cmd_scheduler: RTL and testbench
===================================

Name: ma_cmd_scheduler

Overview:
Front-end scheduler for the memory-access (MA) controller. It arbitrates vector/matrix load-store commands from NUM_REQ requesters round-robin and buffers them in a small command FIFO. It issues them one at a time on the MA start/done handshake, holding the command fields stable until done. It returns a tagged completion to the originating requester and guards each transfer with a watchdog.

Parameters:
NUM_REQ, 2, number of command requesters (>=1)
ID_W, 1, requester id width, >= clog2(NUM_REQ), min 1
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
VRF_ADDRWIDTH, 10, vector/matrix register index width
ARF_ADDRWIDTH, 5, address register index width
ARF_DATAWIDTH, 36, address offset width (= DDR4 address width)
TIMEOUT_CYCLES, 65535, cycles in WAIT_DONE before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester command valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_cmd_i  in  NUM_REQ*CMD_W  packed commands; requester i at [i*CMD_W +: CMD_W]
cpl_valid_o  out  1  completion pulse
cpl_id_o  out  ID_W  requester id of the completed command
cpl_err_o  out  1  completion was a watchdog abort
ma_ddr4_linkup_i  in  1  DDR4 calibration done
ma_start_o  out  1  one-cycle start pulse to the MA controller
ma_select_v_m_o  out  1  1 = matrix, 0 = vector
ma_v_load_or_store_o  out  1  0 = load, 1 = store
ma_v_m_reg_o  out  VRF_ADDRWIDTH  destination/source register index
ma_a_reg_o  out  ARF_ADDRWIDTH  base address register index
ma_a_offset_o  out  ARF_DATAWIDTH  address offset
ma_done_i  in  1  MA done pulse
busy_o  out  1  FIFO non-empty or a command is in flight
err_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Command layout (CMD_W = 2+VRF_ADDRWIDTH+ARF_ADDRWIDTH+ARF_DATAWIDTH), MSB to LSB: select_v_m, load_or_store, v_m_reg, a_reg, a_offset.
- Reset: all outputs 0, FIFO empty, RR pointer 0, FSM in WAIT_LINK, watchdog 0. Reset mid-transfer drops the in-flight command and all queued commands; no completion is emitted.
- Arbitration (combinational):
  - Winner = first valid requester searching from rr_ptr upward, with wrap.
  - req_ready_o[winner] = 1 iff FIFO not full (registered count) and linkup is 1. All other bits are 0.
  - At most one push per cycle. On a push, rr_ptr <= winner+1 mod NUM_REQ.
  - Push is judged on pre-pop occupancy: when full, a same-cycle pop does not enable a push.
- FIFO entry: {id, cmd}. Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- FSM:
  - WAIT_LINK -> IDLE when ma_ddr4_linkup_i = 1.
  - IDLE: if FIFO non-empty, pop, latch the entry into the output registers, go to ISSUE.
  - ISSUE: ma_start_o = 1 for exactly this cycle; watchdog cleared; -> WAIT_DONE.
  - WAIT_DONE: ma_* fields are held stable (the controller reads them here). Watchdog increments each cycle.
    - On ma_done_i: cpl_valid_o = 1 next cycle with the latched id and cpl_err_o = 0; -> IDLE.
    - Otherwise, if TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES-1: err_timeout_o <= 1, completion with cpl_err_o = 1, -> IDLE.
    - If done and timeout coincide, done wins.
- Latency: push at cycle t -> earliest ma_start_o at t+2 when IDLE and the FIFO was empty. Back-to-back: the next ma_start_o comes 2 cycles after ma_done_i.
- ma_done_i outside WAIT_DONE is ignored.
- Linkup loss does not change FSM state after WAIT_LINK; it only blocks new accepts.
- ma_* field outputs keep their last value while IDLE.
- busy_o = FIFO non-empty OR state in {ISSUE, WAIT_DONE}.
- err_timeout_o clears only on rst.

Decomposition:
- Package ma_sched_pkg:
  - state_t enum {WAIT_LINK, IDLE, ISSUE, WAIT_DONE}
  - ma_cmd_t packed struct with the field order above
  - function cmd_width()
- Sub-module ma_cmd_fifo: synchronous FIFO parameterised on WIDTH/DEPTH with push, pop, full, empty, count. Read data is valid while not empty (first-word fall-through).

Test Plan:
- Linkup gating: linkup = 0, req_valid_i = 2'b01 for 10 cycles -> req_ready_o stays 0 and no ma_start_o. Raise linkup -> accept; ma_start_o 2 cycles later with matching fields.
- Single vector load: cmd {0,0,reg=10'h005,a=5'd3,off=36'h100} from req0; ma_done_i 20 cycles after start -> fields stable throughout WAIT_DONE, cpl_valid_o for 1 cycle with id=0 and err=0, busy_o returns to 0.
- Round-robin: both requesters valid continuously, done after 5 cycles each -> accepts alternate 0,1,0,1. With the FIFO full at 4 entries, both ready bits stay 0.
- Push/pop same cycle: FIFO holds 1 entry in IDLE and req1 pushes -> count stays 1 and the order is preserved.
- Watchdog: TIMEOUT_CYCLES = 8, done never asserted -> completion with cpl_err_o = 1 exactly 8 cycles after entering WAIT_DONE, err_timeout_o sticky, next command issued normally. Done and timeout on the same cycle -> err = 0.
- Reset mid-flight: assert rst during WAIT_DONE with 3 entries queued -> all outputs 0 next cycle, no completion, FSM in WAIT_LINK.

Source files
------------

// File: rtl/ma_sched_pkg.sv
// ma_sched_pkg: scheduler state encoding, default command field widths, command layout struct and width helper
package ma_sched_pkg;
  localparam int VRF_AW = 10;
  localparam int ARF_AW = 5;
  localparam int ARF_DW = 36;
  typedef enum logic [1:0] {WAIT_LINK, IDLE, ISSUE, WAIT_DONE} state_t;
  typedef struct packed {
    logic              select_v_m;
    logic              load_or_store;
    logic [VRF_AW-1:0] v_m_reg;
    logic [ARF_AW-1:0] a_reg;
    logic [ARF_DW-1:0] a_offset;
  } ma_cmd_t;
  function automatic int cmd_width(input int vrf_aw, input int arf_aw, input int arf_dw);
    return 2 + vrf_aw + arf_aw + arf_dw;
  endfunction
endpackage

// File: rtl/ma_cmd_fifo.sv
// ma_cmd_fifo: first-word fall-through FIFO; push_i/wdata_i write, pop_i advances, rdata_o valid while !empty_o, full_o/empty_o/count_o status
module ma_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ma_cmd_scheduler.sv
// ma_cmd_scheduler: round-robin command arbiter + FIFO feeding the MA start/done handshake; req_*/cpl_* requester side, ma_* controller side, busy_o/err_timeout_o status
module ma_cmd_scheduler
  import ma_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int VRF_ADDRWIDTH = 10,
  parameter int ARF_ADDRWIDTH = 5,
  parameter int ARF_DATAWIDTH = 36,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CMD_W = cmd_width(VRF_ADDRWIDTH, ARF_ADDRWIDTH, ARF_DATAWIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd_i,
  output logic                       cpl_valid_o,
  output logic [ID_W-1:0]            cpl_id_o,
  output logic                       cpl_err_o,
  input  logic                       ma_ddr4_linkup_i,
  output logic                       ma_start_o,
  output logic                       ma_select_v_m_o,
  output logic                       ma_v_load_or_store_o,
  output logic [VRF_ADDRWIDTH-1:0]   ma_v_m_reg_o,
  output logic [ARF_ADDRWIDTH-1:0]   ma_a_reg_o,
  output logic [ARF_DATAWIDTH-1:0]   ma_a_offset_o,
  input  logic                       ma_done_i,
  output logic                       busy_o,
  output logic                       err_timeout_o
);
  localparam int EW = ID_W + CMD_W;
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, win, id_q, cpl_id_q;
  logic [ID_W:0] idx;
  logic [CMD_W-1:0] cmd_q;
  logic [WD_W-1:0] wd_q;
  logic [EW-1:0] fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic found, push, pop, full, empty, fin, timeout;
  logic cpl_valid_q, cpl_err_q, err_to_q;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win = idx[ID_W-1:0];
      end
    end
    // Occupancy is the registered count, so a same-cycle pop never frees a slot for a push.
    push = found && !full && ma_ddr4_linkup_i && !rst;
    req_ready_o = push ? NUM_REQ'(1) << win : '0;
    rr_d = !push ? rr_q : (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end
  ma_cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .wdata_i({win, req_cmd_i[win*CMD_W +: CMD_W]}),
    .pop_i(pop),
    .rdata_o(fifo_rdata),
    .full_o(full),
    .empty_o(empty),
    .count_o(fifo_cnt)
  );
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    fin = 1'b0;
    timeout = 1'b0;
    case (state_q)
      WAIT_LINK: state_d = ma_ddr4_linkup_i ? IDLE : WAIT_LINK;
      IDLE: begin
        pop = !empty;
        state_d = empty ? IDLE : ISSUE;
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        timeout = !ma_done_i && TIMEOUT_CYCLES != 0 && wd_q == WD_LAST;
        fin = ma_done_i || timeout;
        state_d = fin ? IDLE : WAIT_DONE;
      end
      default: state_d = WAIT_LINK;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LINK;
      rr_q <= '0;
      cmd_q <= '0;
      id_q <= '0;
      wd_q <= '0;
      cpl_valid_q <= 1'b0;
      cpl_id_q <= '0;
      cpl_err_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      if (pop) begin
        cmd_q <= fifo_rdata[CMD_W-1:0];
        id_q <= fifo_rdata[EW-1:CMD_W];
      end
      wd_q <= state_q == ISSUE ? '0 : state_q == WAIT_DONE ? wd_q + 1'b1 : wd_q;
      cpl_valid_q <= fin;
      if (fin) cpl_id_q <= id_q;
      cpl_err_q <= timeout;
      err_to_q <= err_to_q | timeout;
    end
  end
  assign ma_start_o = state_q == ISSUE;
  assign {ma_select_v_m_o, ma_v_load_or_store_o, ma_v_m_reg_o, ma_a_reg_o, ma_a_offset_o} = cmd_q;
  assign busy_o = fifo_cnt != '0 || state_q == ISSUE || state_q == WAIT_DONE;
  assign cpl_valid_o = cpl_valid_q;
  assign cpl_id_o = cpl_id_q;
  assign cpl_err_o = cpl_err_q;
  assign err_timeout_o = err_to_q;
endmodule

// File: tb/tb_ma_cmd_scheduler.sv
// tb_ma_cmd_scheduler: randomized scoreboard bench with a transaction-level timing model of the scheduler
module tb_ma_cmd_scheduler;
  import ma_sched_pkg::*;
  localparam int NR = 2;
  localparam int IW = 1;
  localparam int DEP = 4;
  localparam int TO = 8;
  localparam int CW = cmd_width(VRF_AW, ARF_AW, ARF_DW);
  typedef struct {
    int cyc;
    logic [IW-1:0] id;
    logic err;
    ma_cmd_t cmd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [NR*CW-1:0] req_cmd_i = '0;
  logic cpl_valid_o, cpl_err_o, ma_start_o, ma_select_v_m_o, ma_v_load_or_store_o, busy_o, err_timeout_o;
  logic [IW-1:0] cpl_id_o;
  logic ma_ddr4_linkup_i = 1'b0;
  logic ma_done_i = 1'b0;
  logic [VRF_AW-1:0] ma_v_m_reg_o;
  logic [ARF_AW-1:0] ma_a_reg_o;
  logic [ARF_DW-1:0] ma_a_offset_o;
  ma_cmd_t fields, last_f;
  int n_chk = 0, n_err = 0, cyc = 0, guard;
  int m_rr, link_cyc, inflight_end, last_pop, done_cyc, stray_cyc, err_from;
  bit linked, slow;
  exp_t mq[$], exp_iss[$], exp_cpl[$];
  exp_t mon_e;
  ma_cmd_t c_cmd [NR];
  ma_cmd_scheduler #(
    .NUM_REQ(NR), .ID_W(IW), .FIFO_DEPTH(DEP), .VRF_ADDRWIDTH(VRF_AW),
    .ARF_ADDRWIDTH(ARF_AW), .ARF_DATAWIDTH(ARF_DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cmd_i(req_cmd_i),
    .cpl_valid_o(cpl_valid_o), .cpl_id_o(cpl_id_o), .cpl_err_o(cpl_err_o), .ma_ddr4_linkup_i(ma_ddr4_linkup_i),
    .ma_start_o(ma_start_o), .ma_select_v_m_o(ma_select_v_m_o), .ma_v_load_or_store_o(ma_v_load_or_store_o),
    .ma_v_m_reg_o(ma_v_m_reg_o), .ma_a_reg_o(ma_a_reg_o), .ma_a_offset_o(ma_a_offset_o), .ma_done_i(ma_done_i),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );
  assign fields = {ma_select_v_m_o, ma_v_load_or_store_o, ma_v_m_reg_o, ma_a_reg_o, ma_a_offset_o};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_s <= rst;
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    exp_iss.delete();
    exp_cpl.delete();
    m_rr = 0;
    linked = 0;
    link_cyc = 0;
    inflight_end = 0;
    last_pop = -100;
    done_cyc = -1;
    stray_cyc = -1;
    err_from = 1 << 30;
  endtask
  // One clock of stimulus; the model timeline: pop at p, start at p+1, waiting from p+2,
  // completion one cycle after done, or at p+2+TO when done never comes.
  task automatic step(input logic [NR-1:0] v, input logic lk, input logic r);
    exp_t e;
    int win, d;
    logic [IW-1:0] ix;
    logic [NR-1:0] rdy;
    logic [63:0] r64;
    @(negedge clk);
    rst = r;
    ma_ddr4_linkup_i = lk;
    req_valid_i = v;
    ma_done_i = (cyc == done_cyc) || (cyc == stray_cyc);
    for (int i = 0; i < NR; i++) begin
      r64 = {$urandom(), $urandom()};
      c_cmd[i] = r64[CW-1:0];
      req_cmd_i[i*CW +: CW] = c_cmd[i];
    end
    #1;
    if (r) begin
      check("ready_in_reset", req_ready_o, '0);
      model_reset();
    end else begin
      win = -1;
      for (int k = 0; k < NR; k++) begin
        ix = IW'((m_rr + k) % NR);
        if (win < 0 && v[ix]) win = int'(ix);
      end
      rdy = (win >= 0 && mq.size() < DEP && lk) ? NR'(1) << win : '0;
      check("req_ready", req_ready_o, rdy);
      check("busy", busy_o, mq.size() > 0 || cyc < inflight_end);
      check("err_timeout", err_timeout_o, cyc >= err_from);
      if (linked && cyc >= link_cyc && cyc >= inflight_end && mq.size() > 0) begin
        e = mq.pop_front();
        last_pop = cyc;
        e.cyc = cyc + 1;
        exp_iss.push_back(e);
        d = slow ? TO : $urandom_range(0, TO + 1);
        if (d < TO) begin
          done_cyc = cyc + 2 + d;
          e.err = 1'b0;
          e.cyc = cyc + 3 + d;
        end else begin
          e.err = 1'b1;
          e.cyc = cyc + 2 + TO;
          stray_cyc = cyc + 2 + TO;
          if (err_from > e.cyc) err_from = e.cyc;
        end
        inflight_end = e.cyc;
        exp_cpl.push_back(e);
      end
      if (!linked && lk) begin
        linked = 1;
        link_cyc = cyc + 1;
      end
      if (rdy != '0) begin
        e.id = IW'(win);
        e.cmd = c_cmd[win];
        e.err = 1'b0;
        e.cyc = 0;
        mq.push_back(e);
        m_rr = (win + 1) % NR;
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst_s) begin
      check("reset_ctrl_outputs", {ma_start_o, cpl_valid_o, cpl_err_o, cpl_id_o, busy_o, err_timeout_o}, '0);
      check("reset_fields", fields, '0);
      last_f = '0;
    end else begin
      while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) begin
        check("start_missing", cyc, exp_iss[0].cyc);
        exp_iss.delete(0);
      end
      if (ma_start_o) begin
        if (exp_iss.size() == 0) check("start_unexpected", ma_start_o, 1'b0);
        else begin
          mon_e = exp_iss.pop_front();
          check("start_cycle", cyc, mon_e.cyc);
          check("start_fields", fields, mon_e.cmd);
        end
        last_f = fields;
      end else check("fields_hold", fields, last_f);
      while (exp_cpl.size() > 0 && exp_cpl[0].cyc < cyc) begin
        check("cpl_missing", cyc, exp_cpl[0].cyc);
        exp_cpl.delete(0);
      end
      if (cpl_valid_o) begin
        if (exp_cpl.size() == 0) check("cpl_unexpected", cpl_valid_o, 1'b0);
        else begin
          mon_e = exp_cpl.pop_front();
          check("cpl_cycle", cyc, mon_e.cyc);
          check("cpl_id", cpl_id_o, mon_e.id);
          check("cpl_err", cpl_err_o, mon_e.err);
        end
      end
    end
  end
  initial begin
    model_reset();
    slow = 0;
    repeat (3) step(2'b00, 1'b0, 1'b1);
    repeat (10) step(2'b01, 1'b0, 1'b0);
    repeat (6) step(2'b01, 1'b1, 1'b0);
    repeat (30) step(2'b00, 1'b1, 1'b0);
    slow = 1;
    repeat (60) step(2'b11, 1'b1, 1'b0);
    slow = 0;
    repeat (800) step(2'($urandom()), $urandom_range(0, 7) != 0, 1'b0);
    slow = 1;
    guard = 0;
    while (!(mq.size() >= 3 && cyc + 1 >= last_pop + 2 && cyc + 1 < inflight_end) && guard < 200) begin
      step(2'b11, 1'b1, 1'b0);
      guard++;
    end
    check("midflight_setup", guard < 200, 1'b1);
    step(2'b11, 1'b1, 1'b1);
    slow = 0;
    repeat (4) step(2'b11, 1'b0, 1'b0);
    repeat (200) step(2'($urandom()), 1'b1, 1'b0);
    repeat (80) step(2'b00, 1'b1, 1'b0);
    check("issue_queue_drained", exp_iss.size(), 0);
    check("cpl_queue_drained", exp_cpl.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
